// File: rtl/core_sequencer.sv
// core_sequencer: streams a program image into core imem, pulses core start, then times the run until done.
// Optional RUN watchdog (TOUT state, timeout flag) is built when CORE_SEQ_WATCHDOG_EN is defined.
module core_sequencer #(
    parameter int D = 12,
    parameter int W = 9,
    parameter int CW = 16,
    parameter int START_CYC = 2,
    parameter logic [CW-1:0] TIMEOUT = CW'(4000)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          go,
    input  logic          prog_valid,
    input  logic [W-1:0]  prog_word,
    input  logic          prog_last,
    output logic          prog_ready,
    output logic          imem_we,
    output logic [D-1:0]  imem_addr,
    output logic [W-1:0]  imem_wdata,
    output logic          core_start,
    input  logic          core_done,
    output logic          busy,
    output logic          finished,
    output logic          err_overflow,
    output logic [D:0]    load_count,
    output logic [CW-1:0] cycle_count,
    output logic          timeout
);
    localparam int SW = $clog2(START_CYC + 1);
    typedef enum logic [2:0] {
        IDLE, LOAD, START, RUN, DONE, ERROR
`ifdef CORE_SEQ_WATCHDOG_EN
        , TOUT
`endif
    } state_t;
    state_t state, state_n;
    logic [SW-1:0] sc, sc_n;
    logic [D:0] lc_n;
    logic [CW-1:0] cc_n, cc_inc;
    logic accept;
    assign prog_ready = state == LOAD;
    assign accept = prog_valid & prog_ready;
    assign imem_we = accept;
    assign imem_addr = prog_ready ? load_count[D-1:0] : '0;
    assign imem_wdata = prog_ready ? prog_word : '0;
    assign core_start = state == START;
    assign busy = state == LOAD || state == START || state == RUN;
    assign finished = state == DONE;
    assign err_overflow = state == ERROR;
    assign cc_inc = (cycle_count == '1) ? cycle_count : cycle_count + 1'b1;
`ifdef CORE_SEQ_WATCHDOG_EN
    assign timeout = state == TOUT;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout = 1'b0;
`endif
    // Every non-busy state (IDLE/DONE/ERROR/TOUT) accepts go
    always_comb begin
        state_n = state;
        sc_n = sc;
        lc_n = load_count;
        cc_n = cycle_count;
        if (go && !busy) begin
            state_n = LOAD;
            lc_n = '0;
            cc_n = '0;
        end
        if (accept) begin
            lc_n = load_count + 1'b1;
            sc_n = '0;
            state_n = prog_last ? START : (&load_count[D-1:0]) ? ERROR : LOAD;
        end
        if (state == START) begin
            sc_n = sc + 1'b1;
            state_n = (sc == SW'(START_CYC - 1)) ? RUN : START;
        end
        if (state == RUN) begin
            cc_n = cc_inc;
            state_n = core_done ? DONE : RUN;
`ifdef CORE_SEQ_WATCHDOG_EN
            if (!core_done && cc_inc == TIMEOUT) state_n = TOUT;
`endif
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sc <= '0;
            load_count <= '0;
            cycle_count <= '0;
        end else begin
            state <= state_n;
            sc <= sc_n;
            load_count <= lc_n;
            cycle_count <= cc_n;
        end
    end
endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Run-control stage directly upstream of the single-cycle 9-bit core top level.
- Streams a program image into the core's instruction memory write port over a valid/ready handshake.
- Drives the core's `start` input to reset its PC to `start_address`, then counts execution cycles until the core's `done` rises and reports status.
- Replaces hand-driven testbench sequencing with a reusable synthesizable block.

Parameters:
- D, 12, program-counter / instruction-memory address width (matches core PC width).
- W, 9, machine-code word width.
- CW, 16, cycle-counter width.
- START_CYC, 2, number of cycles `core_start` is held high (minimum 1).
- TIMEOUT, 16'd4000, watchdog limit in RUN cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- go  in  1  begin a session (load, start, run); level-sampled, acted on only in IDLE/DONE/ERROR.
- prog_valid  in  1  program word valid.
- prog_word  in  W  machine-code word.
- prog_last  in  1  marks final word of the image.
- prog_ready  out  1  sequencer accepts a word this cycle.
- imem_we  out  1  instruction-memory write enable.
- imem_addr  out  D  instruction-memory write address.
- imem_wdata  out  W  instruction-memory write data.
- core_start  out  1  to core `start`.
- core_done  in  1  from core `done`.
- busy  out  1  high in LOAD/START/RUN.
- finished  out  1  high in DONE.
- err_overflow  out  1  high in ERROR.
- load_count  out  D+1  words written in the last load.
- cycle_count  out  CW  RUN cycles until `core_done`.
- timeout  out  1  watchdog fired (tied 0 without the feature).

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous, active-low.
  - Reset forces state=IDLE and clears load pointer, load_count and cycle_count to 0.
  - All outputs are 0 during and after reset until `go`.
  - Reset mid-LOAD or mid-RUN abandons the session; no further imem writes.
- States: IDLE, LOAD, START, RUN, DONE, ERROR, plus TOUT with the feature.
- IDLE/DONE/ERROR: `go`=1 → LOAD next cycle.
  - On that transition, clear load pointer, load_count, cycle_count, err_overflow, timeout and finished.
  - `go` is ignored in all other states.
- LOAD:
  - `prog_ready`=1.
  - `imem_we` = prog_valid & prog_ready, combinational.
  - `imem_addr` = load pointer; `imem_wdata` = `prog_word`. Write latency is zero.
  - Each accepted word increments the pointer and load_count.
  - Accepted word with `prog_last`=1 → START.
  - Accepting word index 2^D-1 without `prog_last` → ERROR. That word is still written. load_count = 2^D. No further words are accepted.
  - `prog_valid`=0 stalls indefinitely; no implicit timeout.
- START:
  - `core_start`=1 for exactly START_CYC cycles, then RUN.
  - `core_done` is ignored, because a stale PC value may still assert it.
- RUN:
  - `core_start`=0; cycle_count increments by 1 per cycle.
  - cycle_count saturates at 2^CW-1 and never wraps.
  - `core_done`=1 sampled → DONE on the next edge. cycle_count freezes, including the cycle in which done was seen.
  - `core_done` already high in the first RUN cycle gives cycle_count=1.
- DONE: `finished`=1 held. cycle_count and load_count are held stable until the next `go`.
- ERROR: `err_overflow`=1 held. `core_start` is never asserted.
- `prog_ready`=0 in every state except LOAD.

Optional Feature:
- Macro: CORE_SEQ_WATCHDOG_EN.
- Defined:
  - In RUN, if cycle_count reaches TIMEOUT before `core_done`, go to TOUT.
  - TOUT sets `timeout`=1 (held), freezes cycle_count=TIMEOUT, and `busy`=0.
  - `go` from TOUT restarts as from DONE.
  - If `core_done` and the limit coincide in the same cycle, done wins → DONE.
- Undefined: TOUT state is absent; `timeout` is tied to 0; RUN waits for `core_done` indefinitely (saturating counter).

Test Plan:
- Reset: `rst_n`=0 mid-RUN → all outputs 0 immediately; after release, state IDLE, `prog_ready`=0, cycle_count=0.
- Normal load: `go`, then 5 words 0x1A0..0x1A4 with `prog_last` on the 5th → imem writes to addr 0..4 with matching data; load_count=5; `core_start` high exactly 2 cycles.
- Backpressure/gaps: `prog_valid` toggled 1,0,0,1 → only 2 writes at addr 0,1; no write on idle cycles.
- Run timing: `core_done` raised 10 cycles after `core_start` falls → `finished`=1, cycle_count=10, values stable; a `go` pulse during RUN is ignored.
- Overflow with D=3: 8 words without `prog_last` → 8 writes (addr 0..7), `err_overflow`=1, load_count=8, `prog_ready`=0, no `core_start`.
- Watchdog (feature on, TIMEOUT=20): `core_done` never rises → `timeout`=1 with cycle_count=20; `go` restarts load cleanly with `timeout` cleared.
